// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - funct3 encodings of the eight M-extension ops
//   - FSM state encoding (StIdle/StBusy/StFix/StDone)
//   - op decode helpers: is_div, is_signed_a, is_signed_b, want_hi, is_rem
package muldiv_pkg;

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpMulhu  = 3'b011;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpDivu   = 3'b101;
    localparam logic [2:0] OpRem    = 3'b110;
    localparam logic [2:0] OpRemu   = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StFix  = 2'b10,
        StDone = 2'b11
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
    endfunction

    // MULH/MULHSU/MULHU return the upper half of the product.
    function automatic logic want_hi(input logic [2:0] op);
        return !op[2] && (op[1:0] != 2'b00);
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return op[2] && op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration shared by multiply and divide.
//   acc       in   2*XLEN  working register {hi, lo}
//   operand_b in   XLEN    |b| (multiplicand or divisor)
//   is_div    in   1       select restoring-divide step instead of shift-add
//   acc_next  out  2*XLEN  register value after this step
// Multiply: lo holds the remaining multiplier bits; add |b| into hi when lo[0] is set,
// then shift the whole accumulator right by one.
// Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand_b,
    input  logic              is_div,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand_b} : {(XLEN+1){1'b0}});
        shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff    = shifted - {1'b0, operand_b};
        acc_next = {mul_sum, acc[XLEN-1:1]};
        if (is_div) begin
            // Partial remainder stays below the divisor, so diff[XLEN] is exactly the borrow.
            if (!diff[XLEN]) begin
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit, one op in flight.
// Optional build macro: MULDIV_EARLY_OUT_EN -- div-by-zero, DIV overflow and zero-operand ops
// skip the iterative phase (latency 2 instead of XLEN+2); results are identical either way.
// Ports:
//   clk, reset_n                clock, asynchronous active-low reset
//   stall                       freezes all state and blocks both handshakes
//   flush                       kills any in-flight op (returns to idle)
//   req_valid/req_ready         request handshake; req_op (funct3), req_a, req_b, req_tag
//   resp_valid/resp_ready       response handshake; resp_data, resp_tag
//   busy                        unit not idle
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int unsigned     CntW   = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

    state_e state_q, state_d;

    logic [2:0]        op_q;
    logic [TAG_W-1:0]  tag_q;
    logic [XLEN-1:0]   a_abs_q, b_abs_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CntW-1:0]   cnt_q;
    logic              neg_a_q, neg_res_q;
    logic              div_zero_q, ovf_q, zero_q;
    logic [XLEN-1:0]   resp_data_q;

    logic              accept, fire;
    logic              req_neg_a, req_neg_b;
    logic [XLEN-1:0]   req_abs_a, req_abs_b;
    logic              req_div_zero, req_ovf, req_zero, early_out;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, a_signed, fix_result;

    assign accept = req_valid && req_ready;
    assign fire   = resp_valid && resp_ready && !stall && !flush;

    // Request decode: magnitudes, sign and special-case flags captured at accept.
    always_comb begin
        req_neg_a    = is_signed_a(req_op) && req_a[XLEN-1];
        req_neg_b    = is_signed_b(req_op) && req_b[XLEN-1];
        req_abs_a    = req_neg_a ? (~req_a + 1'b1) : req_a;
        req_abs_b    = req_neg_b ? (~req_b + 1'b1) : req_b;
        req_div_zero = is_div(req_op) && (req_b == '0);
        req_ovf      = is_div(req_op) && is_signed_a(req_op) && (req_a == MinVal) && (req_b == '1);
        req_zero     = (req_a == '0) || (!is_div(req_op) && (req_b == '0));
`ifdef MULDIV_EARLY_OUT_EN
        early_out    = req_div_zero || req_ovf || req_zero;
`else
        early_out    = 1'b0;
`endif
    end

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .acc      (acc_q),
        .operand_b(b_abs_q),
        .is_div   (is_div(op_q)),
        .acc_next (acc_step)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; flush overrides stall.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StIdle;
        end else if (!stall) begin
            unique case (state_q)
                StIdle:  if (accept) state_d = early_out ? StFix : StBusy;
                StBusy:  if (cnt_q == '0) state_d = StFix;
                StFix:   state_d = StDone;
                StDone:  if (fire) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        req_ready  = (state_q == StIdle) && !stall && !flush;
        resp_valid = (state_q == StDone);
        busy       = (state_q != StIdle);
        resp_data  = resp_data_q;
        resp_tag   = tag_q;
    end

    // Sign correction and result selection; special cases come from accept-time flags only.
    always_comb begin
        prod     = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quo      = acc_q[XLEN-1:0];
        rem      = acc_q[2*XLEN-1:XLEN];
        a_signed = neg_a_q ? (~a_abs_q + 1'b1) : a_abs_q;
        if (is_div(op_q)) begin
            if (div_zero_q) begin
                fix_result = is_rem(op_q) ? a_signed : '1;
            end else if (ovf_q) begin
                fix_result = is_rem(op_q) ? '0 : MinVal;
            end else if (zero_q) begin
                fix_result = '0;
            end else if (is_rem(op_q)) begin
                fix_result = neg_a_q ? (~rem + 1'b1) : rem;
            end else begin
                fix_result = neg_res_q ? (~quo + 1'b1) : quo;
            end
        end else if (zero_q) begin
            fix_result = '0;
        end else begin
            fix_result = want_hi(op_q) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q        <= '0;
            tag_q       <= '0;
            a_abs_q     <= '0;
            b_abs_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_a_q     <= 1'b0;
            neg_res_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            resp_data_q <= '0;
        end else if (accept) begin
            op_q       <= req_op;
            tag_q      <= req_tag;
            a_abs_q    <= req_abs_a;
            b_abs_q    <= req_abs_b;
            // Both mul and div start from {0, |a|}.
            acc_q      <= {{XLEN{1'b0}}, req_abs_a};
            cnt_q      <= CntW'(XLEN - 1);
            neg_a_q    <= req_neg_a;
            neg_res_q  <= req_neg_a ^ req_neg_b;
            div_zero_q <= req_div_zero;
            ovf_q      <= req_ovf;
            zero_q     <= req_zero;
        end else if (!stall && !flush) begin
            if (state_q == StBusy) begin
                acc_q <= acc_step;
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
            if (state_q == StFix) begin
                resp_data_q <= fix_result;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed spec cases, randomized ops
// against an arithmetic reference model, flush, stall/backpressure and mid-op reset.
module tb_muldiv_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;
    localparam logic [31:0] MIN   = 32'h8000_0000;

    logic              clk = 1'b0;
    logic              reset_n, stall, flush;
    logic              req_valid, req_ready, resp_valid, resp_ready, busy;
    logic [2:0]        req_op;
    logic [XLEN-1:0]   req_a, req_b, resp_data;
    logic [TAG_W-1:0]  req_tag, resp_tag;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_unit #(
        .XLEN (XLEN),
        .TAG_W(TAG_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall     (stall),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_tag  (resp_tag),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M semantics via 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (op[2] && b == 32'd0) begin
            p = op[1] ? ua : 64'hFFFF_FFFF;
        end else begin
            case (op)
                3'd0:    p = sa * sb;
                3'd1:    p = (sa * sb) >> 32;
                3'd2:    p = (sa * ub) >> 32;
                3'd3:    p = (ua * ub) >> 32;
                3'd4:    p = $signed(sa) / $signed(sb);
                3'd5:    p = ua / ub;
                3'd6:    p = $signed(sa) % $signed(sb);
                default: p = ua % ub;
            endcase
        end
        return p[31:0];
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        logic early;
        int   early_lat;
        early = op[2] ? (b == 0 || a == 0 || (!op[0] && a == MIN && b == 32'hFFFF_FFFF))
                      : (a == 0 || b == 0);
`ifdef MULDIV_EARLY_OUT_EN
        early_lat = 2;
`else
        early_lat = 34;
`endif
        return early ? early_lat : 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return MIN;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op with resp_ready=1 and check data, tag, latency and return to idle.
    // Entered and left at a falling edge.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
        int lat;
        int guard;
        req_op     = op;
        req_a      = a;
        req_b      = b;
        req_tag    = tag;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        guard      = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat       = 1;
        while (!resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({name, " data"}, 64'(resp_data), 64'(exp));
        check({name, " tag"}, 64'(resp_tag), 64'(tag));
        check({name, " latency"}, 64'(lat), 64'(ref_latency(op, a, b)));
        @(negedge clk);
        check({name, " idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [31:0] held_d;
        logic [4:0]  held_t;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset_n = 1'b0; stall = 1'b0; flush = 1'b0; req_valid = 1'b0;
        req_op = '0; req_a = '0; req_b = '0; req_tag = '0; resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset req_ready", 64'(req_ready), 64'(1));
        check("reset resp_valid", 64'(resp_valid), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset resp_data", 64'(resp_data), 64'(0));
        check("reset resp_tag", 64'(resp_tag), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases with hand-derived results.
        run_op("mul 7*6", 3'd0, 32'd7, 32'd6, 5'd3, 32'd42);
        run_op("mulh -1*-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'd0);
        run_op("mulhu max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE);
        run_op("mulhsu -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd6, 32'hFFFF_FFFF);
        run_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD);
        run_op("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF);
        run_op("divu 100/7", 3'd5, 32'd100, 32'd7, 5'd9, 32'd14);
        run_op("remu 100/7", 3'd7, 32'd100, 32'd7, 5'd10, 32'd2);
        run_op("div 5/0", 3'd4, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF);
        run_op("remu 5/0", 3'd7, 32'd5, 32'd0, 5'd12, 32'd5);
        run_op("rem -5/0", 3'd6, 32'hFFFF_FFFB, 32'd0, 5'd13, 32'hFFFF_FFFB);
        run_op("div min/-1", 3'd4, MIN, 32'hFFFF_FFFF, 5'd14, MIN);
        run_op("rem min/-1", 3'd6, MIN, 32'hFFFF_FFFF, 5'd15, 32'd0);
        run_op("mul 0*x", 3'd0, 32'd0, 32'd1234, 5'd16, 32'd0);
        run_op("div 0/3", 3'd4, 32'd0, 32'd3, 5'd17, 32'd0);
        run_op("mulhu big", 3'd3, 32'h8000_0001, 32'h0001_0000, 5'd18, 32'h0000_8000);

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, 5'($urandom_range(0, 31)),
                   ref_result(rop, ra, rb));
        end

        // Flush presented with a request in IDLE: not accepted.
        req_op = 3'd0; req_a = 32'd9; req_b = 32'd9; req_tag = 5'd1;
        req_valid = 1'b1; flush = 1'b1;
        #1 check("flush idle req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        check("flush idle no accept", 64'(busy), 64'(0));

        // Flush at BUSY step 10 kills the op.
        req_op = 3'd0; req_a = 32'd12345; req_b = 32'd678; req_tag = 5'd7; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("flush busy started", 64'(busy), 64'(1));
        repeat (9) @(negedge clk);
        flush = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        check("flush busy to idle", 64'(busy), 64'(0));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) seen++;
            @(negedge clk);
        end
        check("flush no resp", 64'(seen), 64'(0));
        run_op("mul 3*3 after flush", 3'd0, 32'd3, 32'd3, 5'd2, 32'd9);

        // Stall 5 cycles mid-BUSY, then hold in DONE with resp_ready low.
        req_op = 3'd5; req_a = 32'd1000; req_b = 32'd7; req_tag = 5'd21;
        req_valid = 1'b1; resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        repeat (5) begin @(negedge clk); lat++; end
        stall = 1'b1;
        repeat (5) begin @(negedge clk); lat++; end
        stall = 1'b0;
        while (!resp_valid && lat < 200) begin @(negedge clk); lat++; end
        check("stall latency", 64'(lat), 64'(39));
        check("stall data", 64'(resp_data), 64'(142));
        held_d = resp_data;
        held_t = resp_tag;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d valid", i), 64'(resp_valid), 64'(1));
            check($sformatf("hold%0d data", i), 64'(resp_data), 64'(held_d));
            check($sformatf("hold%0d tag", i), 64'(resp_tag), 64'(5'd21));
            check($sformatf("hold%0d req_ready", i), 64'(req_ready), 64'(0));
        end
        check("held tag", 64'(held_t), 64'(5'd21));
        stall = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        check("stall blocks fire", 64'(resp_valid), 64'(1));
        stall = 1'b0;
        @(negedge clk);
        check("fire after stall", 64'(resp_valid), 64'(0));
        check("idle after fire", 64'(busy), 64'(0));

        // Asynchronous reset mid-op discards the op and clears outputs.
        req_op = 3'd0; req_a = 32'd5; req_b = 32'd5; req_tag = 5'd30; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async reset busy", 64'(busy), 64'(0));
        check("async reset resp_data", 64'(resp_data), 64'(0));
        check("async reset resp_tag", 64'(resp_tag), 64'(0));
        check("async reset resp_valid", 64'(resp_valid), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_op("mul 2*3 after reset", 3'd0, 32'd2, 32'd3, 5'd19, 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
